// File: rtl/trace_frame_uart_if.sv
// Capture-FIFO to trace framer handshake: show-ahead head entry, non-empty flag, pop strobe.
interface trace_frame_uart_if;
    logic [39:0] ent_data;
    logic        ent_valid;
    logic        ent_pop;

    // FIFO side presents the head entry and consumes pops
    modport master (
        output ent_data,
        output ent_valid,
        input  ent_pop
    );

    // Framer side reads the head entry and issues pops
    modport slave (
        input  ent_data,
        input  ent_valid,
        output ent_pop
    );
endinterface

// File: rtl/trace_frame_uart.sv
// Trace entry framer + 8N1 UART transmitter.
// Pops one 40-bit {probes, stamp} entry from the capture FIFO and sends
// SYNC_BYTE, probes, stamp[31:24] .. stamp[7:0] back-to-back on o_tx.
// Optional macro TRACE_FRAME_CSUM_EN appends an XOR checksum of the five
// payload bytes as a seventh byte.
module trace_frame_uart #(
    parameter int unsigned CLK_HZ    = 24000000,
    parameter int unsigned BAUD      = 115200,
    parameter logic [7:0]  SYNC_BYTE = 8'hAA
) (
    input  logic                     clk,
    input  logic                     reset,
    trace_frame_uart_if.slave        ent_if,
    output logic                     o_tx,
    output logic                     o_busy,
    output logic [15:0]              o_frames_sent
);

    localparam int unsigned DIV   = CLK_HZ / BAUD;
    localparam int unsigned TMR_W = (DIV < 2) ? 1 : $clog2(DIV);
`ifdef TRACE_FRAME_CSUM_EN
    localparam int unsigned NBYTES = 7;
`else
    localparam int unsigned NBYTES = 6;
`endif
    localparam int unsigned FRAME_W   = NBYTES * 8;
    localparam logic [2:0]  LAST_BYTE = 3'(NBYTES - 1);

    // A bit period shorter than two clocks cannot be timed by the bit counter
    if (DIV < 2) begin : g_div_check
        $error("trace_frame_uart: CLK_HZ/BAUD must be at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t               r_state;
    logic                 r_tx;
    logic                 r_pop;
    logic [FRAME_W-1:0]   r_frame;
    logic [7:0]           r_sh;
    logic [TMR_W-1:0]     r_timer;
    logic [2:0]           r_bit;
    logic [2:0]           r_byte;
    logic [15:0]          r_frames;

    logic                 w_bit_end;
    logic [FRAME_W-1:0]   w_load;

    // Last clock of the current bit cell
    assign w_bit_end = (r_timer == TMR_W'(DIV - 1));

`ifdef TRACE_FRAME_CSUM_EN
    logic [7:0] w_csum;

    // Checksum covers probes and the four stamp bytes, not the sync byte
    assign w_csum = ent_if.ent_data[39:32] ^ ent_if.ent_data[31:24] ^
                    ent_if.ent_data[23:16] ^ ent_if.ent_data[15:8]  ^
                    ent_if.ent_data[7:0];
    assign w_load = {SYNC_BYTE, ent_if.ent_data, w_csum};
`else
    assign w_load = {SYNC_BYTE, ent_if.ent_data};
`endif

    assign o_tx          = r_tx;
    assign ent_if.ent_pop = r_pop;
    assign o_busy        = (r_state != S_IDLE);
    assign o_frames_sent = r_frames;

    // Frame sequencer: pop, latch, then shift bytes MSB-byte-first, bits LSB-first
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_tx     <= 1'b1;
            r_pop    <= 1'b0;
            r_frame  <= '0;
            r_sh     <= '0;
            r_timer  <= '0;
            r_bit    <= '0;
            r_byte   <= '0;
            r_frames <= '0;
        end else begin
            r_pop <= 1'b0;
            if (r_state != S_IDLE) begin
                r_timer <= w_bit_end ? '0 : r_timer + TMR_W'(1);
            end
            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    // Pop is issued one cycle, the entry is latched as the FIFO advances
                    if (r_pop) begin
                        r_frame <= w_load;
                        r_byte  <= '0;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end else if (ent_if.ent_valid) begin
                        r_pop <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_sh    <= r_frame[FRAME_W-1 -: 8];
                        r_frame <= r_frame << 8;
                        r_bit   <= '0;
                        r_tx    <= r_frame[FRAME_W-8];
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                            r_sh  <= r_sh >> 1;
                            r_tx  <= r_sh[1];
                        end
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        if (r_byte == LAST_BYTE) begin
                            r_frames <= r_frames + 16'd1;
                            r_state  <= S_IDLE;
                            // First IDLE cycle may already carry the next pop
                            if (ent_if.ent_valid) begin
                                r_pop <= 1'b1;
                            end
                        end else begin
                            r_byte  <= r_byte + 3'd1;
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trace_frame_uart.sv
// Directed bench for trace_frame_uart at CLK_HZ=1000, BAUD=250 (4 clocks per bit).
// A queue models the show-ahead capture FIFO; a UART receiver decodes o_tx.
module tb_trace_frame_uart;

    localparam int unsigned DIV = 4;
`ifdef TRACE_FRAME_CSUM_EN
    localparam int unsigned NB = 7;
`else
    localparam int unsigned NB = 6;
`endif
    localparam int FRAME_CYC  = NB * 10 * DIV;
    localparam int RX_TIMEOUT = 3000;

    typedef logic [7:0] frame_t [NB];
    typedef int         starts_t [NB];
    typedef logic       stops_t [NB];

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        tx;
    logic        busy;
    logic [15:0] frames_sent;

    trace_frame_uart_if ent_if();

    trace_frame_uart #(
        .CLK_HZ   (1000),
        .BAUD     (250),
        .SYNC_BYTE(8'hAA)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ent_if       (ent_if),
        .o_tx         (tx),
        .o_busy       (busy),
        .o_frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [39:0] fifo [$];
    int          pop_cyc [$];
    int          busy_run      = 0;
    int          last_busy_len = 0;

    // FIFO pop side and pop timestamps
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ent_if.ent_pop === 1'b1) begin
            pop_cyc.push_back(cyc);
            if (fifo.size() > 0) void'(fifo.pop_front());
        end
    end

    // FIFO head presentation and busy-length monitor
    always @(negedge clk) begin
        if (fifo.size() > 0) begin
            ent_if.ent_valid = 1'b1;
            ent_if.ent_data  = fifo[0];
        end else begin
            ent_if.ent_valid = 1'b0;
            ent_if.ent_data  = 40'hA5_5A5A5A5A;
        end
        if (busy === 1'b1) begin
            busy_run = busy_run + 1;
        end else if (busy_run != 0) begin
            last_busy_len = busy_run;
            busy_run      = 0;
        end
    end

    function automatic logic [7:0] exp_byte(input logic [39:0] e, input int k);
        case (k)
            0:       return 8'hAA;
            1:       return e[39:32];
            2:       return e[31:24];
            3:       return e[23:16];
            4:       return e[15:8];
            5:       return e[7:0];
            default: return e[39:32] ^ e[31:24] ^ e[23:16] ^ e[15:8] ^ e[7:0];
        endcase
    endfunction

    task automatic rx_byte(output logic [7:0] b, output logic stop, output int t0, output bit to);
        int waited;
        waited = 0;
        b = '0; stop = 1'b0; t0 = 0; to = 1'b0;
        @(negedge clk);
        while (tx !== 1'b0 && waited < RX_TIMEOUT) begin
            @(negedge clk);
            waited++;
        end
        if (tx !== 1'b0) begin
            to = 1'b1;
            return;
        end
        t0 = cyc;
        repeat (DIV + 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            b[i] = tx;
            repeat (DIV) @(negedge clk);
        end
        stop = tx;
    endtask

    task automatic rx_frame(output frame_t bytes, output starts_t st, output stops_t sp, output bit to);
        bit t;
        to = 1'b0;
        for (int k = 0; k < NB; k++) begin
            bytes[k] = '0; st[k] = 0; sp[k] = 1'b0;
        end
        for (int k = 0; k < NB; k++) begin
            rx_byte(bytes[k], sp[k], st[k], t);
            if (t) begin
                to = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        fifo.push_back(40'h01_00000010);
        repeat (2) @(negedge clk);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_checks++;
            if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx cyc%0d: got %b expected 1", c, tx); end
            n_checks++;
            if (ent_if.ent_pop !== 1'b0) begin n_fail++; $display("FAIL reset_pop cyc%0d: got %b expected 0", c, ent_if.ent_pop); end
            n_checks++;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy cyc%0d: got %b expected 0", c, busy); end
            n_checks++;
            if (frames_sent !== 16'h0000) begin n_fail++; $display("FAIL reset_frames cyc%0d: got %h expected 0000", c, frames_sent); end
        end
        n_checks++;
        if (pop_cyc.size() != 0) begin n_fail++; $display("FAIL reset_popcount: got %0d expected 0", pop_cyc.size()); end
    endtask

    task automatic test_single();
        frame_t      got;
        starts_t     st;
        stops_t      sp;
        bit          to;
        int          p0;
        logic [39:0] e;
        e  = 40'h01_00000010;
        p0 = pop_cyc.size();
        @(negedge clk);
        reset = 1'b1;
        rx_frame(got, st, sp, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL single_timeout: got no frame expected %0d bytes", NB); end
        for (int k = 0; k < NB; k++) begin
            n_checks++;
            if (got[k] !== exp_byte(e, k)) begin n_fail++; $display("FAIL single_byte%0d: got %h expected %h", k, got[k], exp_byte(e, k)); end
            n_checks++;
            if (sp[k] !== 1'b1) begin n_fail++; $display("FAIL single_stop%0d: got %b expected 1", k, sp[k]); end
            if (k > 0) begin
                n_checks++;
                if (st[k] - st[k-1] != 10 * DIV) begin n_fail++; $display("FAIL single_gap%0d: got %0d expected %0d", k, st[k] - st[k-1], 10 * DIV); end
            end
        end
        repeat (4 * DIV) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b expected 0", busy); end
        n_checks++;
        if (last_busy_len != FRAME_CYC) begin n_fail++; $display("FAIL single_busy_len: got %0d expected %0d", last_busy_len, FRAME_CYC); end
        n_checks++;
        if (frames_sent !== 16'd1) begin n_fail++; $display("FAIL single_frames: got %0d expected 1", frames_sent); end
        n_checks++;
        if (pop_cyc.size() - p0 != 1) begin n_fail++; $display("FAIL single_pops: got %0d expected 1", pop_cyc.size() - p0); end
    endtask

    task automatic test_back_to_back();
        frame_t      got;
        starts_t     st;
        stops_t      sp;
        bit          to;
        int          p0;
        logic [39:0] ents [3];
        ents[0] = 40'h5A_12345678;
        ents[1] = 40'hC3_0F1E2D3C;
        ents[2] = 40'h80_00000001;
        p0 = pop_cyc.size();
        @(negedge clk);
        for (int f = 0; f < 3; f++) fifo.push_back(ents[f]);
        for (int f = 0; f < 3; f++) begin
            rx_frame(got, st, sp, to);
            n_checks++;
            if (to) begin n_fail++; $display("FAIL b2b_timeout f%0d: got no frame expected %0d bytes", f, NB); end
            for (int k = 0; k < NB; k++) begin
                n_checks++;
                if (got[k] !== exp_byte(ents[f], k)) begin n_fail++; $display("FAIL b2b_byte f%0d b%0d: got %h expected %h", f, k, got[k], exp_byte(ents[f], k)); end
                if (k > 0) begin
                    n_checks++;
                    if (st[k] - st[k-1] != 10 * DIV) begin n_fail++; $display("FAIL b2b_gap f%0d b%0d: got %0d expected %0d", f, k, st[k] - st[k-1], 10 * DIV); end
                end
            end
        end
        repeat (4 * DIV) @(negedge clk);
        n_checks++;
        if (pop_cyc.size() - p0 != 3) begin
            n_fail++; $display("FAIL b2b_pops: got %0d expected 3", pop_cyc.size() - p0);
        end else begin
            for (int f = 1; f < 3; f++) begin
                n_checks++;
                if (pop_cyc[p0+f] - pop_cyc[p0+f-1] != FRAME_CYC + 1) begin
                    n_fail++; $display("FAIL b2b_spacing %0d: got %0d expected %0d", f, pop_cyc[p0+f] - pop_cyc[p0+f-1], FRAME_CYC + 1);
                end
            end
        end
        n_checks++;
        if (frames_sent !== 16'd4) begin n_fail++; $display("FAIL b2b_frames: got %0d expected 4", frames_sent); end
    endtask

    task automatic test_reset_mid();
        frame_t      got;
        starts_t     st;
        stops_t      sp;
        bit          to;
        int          waited;
        int          pn;
        logic [39:0] e;
        e = 40'h3C_00C0FFEE;
        @(negedge clk);
        fifo.push_back(40'h77_CAFEF00D);
        waited = 0;
        while (tx !== 1'b0 && waited < RX_TIMEOUT) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (tx !== 1'b0) begin n_fail++; $display("FAIL mid_start_timeout: got tx %b expected 0", tx); end
        repeat (3 * 10 * DIV + 4 * DIV) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL mid_tx: got %b expected 1", tx); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b expected 0", busy); end
        n_checks++;
        if (frames_sent !== 16'd0) begin n_fail++; $display("FAIL mid_frames: got %0d expected 0", frames_sent); end
        pn = pop_cyc.size();
        fifo.push_back(e);
        repeat (6) @(negedge clk);
        n_checks++;
        if (pop_cyc.size() != pn) begin n_fail++; $display("FAIL mid_pop_in_reset: got %0d expected %0d", pop_cyc.size(), pn); end
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL mid_tx_hold: got %b expected 1", tx); end
        reset = 1'b1;
        rx_frame(got, st, sp, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL mid_timeout: got no frame expected %0d bytes", NB); end
        for (int k = 0; k < NB; k++) begin
            n_checks++;
            if (got[k] !== exp_byte(e, k)) begin n_fail++; $display("FAIL mid_byte%0d: got %h expected %h", k, got[k], exp_byte(e, k)); end
        end
        repeat (4 * DIV) @(negedge clk);
        n_checks++;
        if (frames_sent !== 16'd1) begin n_fail++; $display("FAIL mid_frames_after: got %0d expected 1", frames_sent); end
        n_checks++;
        if (pop_cyc.size() - pn != 1) begin n_fail++; $display("FAIL mid_pops: got %0d expected 1", pop_cyc.size() - pn); end
    endtask

    task automatic test_wrap();
        frame_t      got;
        starts_t     st;
        stops_t      sp;
        bit          to;
        logic [39:0] e;
        e = 40'hFF_DEADBEEF;
        @(negedge clk);
        force dut.r_frames = 16'hFFFF;
        @(negedge clk);
        release dut.r_frames;
        @(negedge clk);
        n_checks++;
        if (frames_sent !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h expected ffff", frames_sent); end
        fifo.push_back(e);
        rx_frame(got, st, sp, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL wrap_timeout: got no frame expected %0d bytes", NB); end
        for (int k = 0; k < NB; k++) begin
            n_checks++;
            if (got[k] !== exp_byte(e, k)) begin n_fail++; $display("FAIL wrap_byte%0d: got %h expected %h", k, got[k], exp_byte(e, k)); end
        end
        repeat (4 * DIV) @(negedge clk);
        n_checks++;
        if (frames_sent !== 16'h0000) begin n_fail++; $display("FAIL wrap_frames: got %h expected 0000", frames_sent); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
